// File: rtl/sequential_sobel_x_if.sv
// Data bundle between a column producer and the sequential horizontal Sobel stage.
// There is no handshake: every signal is valid on every clock cycle.
interface sequential_sobel_x_if;
  logic [7:0] current_in;
  logic [9:0] left_intermediate;
  logic [9:0] right_intermediate;
  logic [9:0] current_intermediate;
  logic [9:0] sobel_X_out;

  modport master (
    output current_in,
    output left_intermediate,
    output right_intermediate,
    input  current_intermediate,
    input  sobel_X_out
  );

  modport slave (
    input  current_in,
    input  left_intermediate,
    input  right_intermediate,
    output current_intermediate,
    output sobel_X_out
  );
endinterface

// File: rtl/sequential_sobel_x.sv
// Sequential Sobel-X stage: vertically smooths one column (weights 1,2,1) over three
// cycles and registers |right - left| of the neighbouring smoothed columns every cycle.
module sequential_sobel_x (
  input  logic                  clk,
  input  logic                  rst,
  sequential_sobel_x_if.slave   bus
);

  localparam logic [1:0] PH_TOP = 2'd0;
  localparam logic [1:0] PH_MID = 2'd1;
  localparam logic [1:0] PH_BOT = 2'd2;

  logic [1:0] phase;
  logic [9:0] acc;
  logic [9:0] col_sum;
  logic [9:0] mid_sum;
  logic [9:0] current_intermediate_q;
  logic [9:0] sobel_x_q;

  logic signed [10:0] diff;
  logic [9:0]         abs_diff;

  // 10 bits hold the worst case 255 + 2*255 + 255 = 1020 without wrapping.
  assign mid_sum = acc + {1'b0, bus.current_in, 1'b0};
  assign col_sum = acc + {2'b00, bus.current_in};

  // A 10-bit magnitude always fits once the sign is stripped (max 1023).
  assign diff     = $signed({1'b0, bus.right_intermediate}) - $signed({1'b0, bus.left_intermediate});
  assign abs_diff = diff[10] ? 10'(-diff) : diff[9:0];

  // NOTE: all state below is flops updated with non-blocking assignments, so every
  // register samples pre-edge values and the phase/accumulator pair stays consistent.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase                  <= PH_TOP;
      acc                    <= '0;
      current_intermediate_q <= '0;
      sobel_x_q              <= '0;
    end else begin
      sobel_x_q <= abs_diff;
      case (phase)
        PH_TOP: begin
          acc   <= {2'b00, bus.current_in};
          phase <= PH_MID;
        end
        PH_MID: begin
          acc   <= mid_sum;
          phase <= PH_BOT;
        end
        PH_BOT: begin
          current_intermediate_q <= col_sum;
          acc                    <= '0;
          phase                  <= PH_TOP;
        end
        default: begin
          // Unreachable encoding; recover to the top row with a clean accumulator.
          acc   <= '0;
          phase <= PH_TOP;
        end
      endcase
    end
  end

  assign bus.current_intermediate = current_intermediate_q;
  assign bus.sobel_X_out          = sobel_x_q;

endmodule

// File: tb/tb_sequential_sobel_x.sv
// Directed bench for sequential_sobel_x: column smoothing, gradient magnitude and reset.
module tb_sequential_sobel_x;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  sequential_sobel_x_if ifc ();

  sequential_sobel_x dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests_run);
    $fatal(1, "watchdog expired");
  end

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] cur, input logic [9:0] l, input logic [9:0] r);
    ifc.current_in         = cur;
    ifc.left_intermediate  = l;
    ifc.right_intermediate = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(8'd200, 10'd0, 10'd100);
    rst = 1'b1;
    step();
    tests_run++;
    if (ifc.current_intermediate !== 10'd0) begin
      $display("FAIL reset_ci: got %0d expected 0", ifc.current_intermediate);
      tests_failed++;
    end
    tests_run++;
    if (ifc.sobel_X_out !== 10'd0) begin
      $display("FAIL reset_sobel: got %0d expected 0", ifc.sobel_X_out);
      tests_failed++;
    end
    step();
    step();
    tests_run++;
    if (ifc.current_intermediate !== 10'd0 || ifc.sobel_X_out !== 10'd0) begin
      $display("FAIL reset_hold: ci %0d sobel %0d expected 0 0",
               ifc.current_intermediate, ifc.sobel_X_out);
      tests_failed++;
    end
    rst = 1'b0;
  endtask

  task automatic test_column();
    drive(8'd88, 10'd0, 10'd0);
    step();
    tests_run++;
    if (ifc.current_intermediate !== 10'd0) begin
      $display("FAIL column_early1: got %0d expected 0", ifc.current_intermediate);
      tests_failed++;
    end
    drive(8'd121, 10'd0, 10'd0);
    step();
    tests_run++;
    if (ifc.current_intermediate !== 10'd0) begin
      $display("FAIL column_early2: got %0d expected 0", ifc.current_intermediate);
      tests_failed++;
    end
    drive(8'd60, 10'd0, 10'd0);
    step();
    tests_run++;
    if (ifc.current_intermediate !== 10'd390) begin
      $display("FAIL column_390: got %0d expected 390", ifc.current_intermediate);
      tests_failed++;
    end
    // Next column of zeros: 390 must hold for two edges, then become 0.
    drive(8'd0, 10'd0, 10'd0);
    step();
    tests_run++;
    if (ifc.current_intermediate !== 10'd390) begin
      $display("FAIL column_hold1: got %0d expected 390", ifc.current_intermediate);
      tests_failed++;
    end
    step();
    tests_run++;
    if (ifc.current_intermediate !== 10'd390) begin
      $display("FAIL column_hold2: got %0d expected 390", ifc.current_intermediate);
      tests_failed++;
    end
    step();
    tests_run++;
    if (ifc.current_intermediate !== 10'd0) begin
      $display("FAIL column_zero: got %0d expected 0", ifc.current_intermediate);
      tests_failed++;
    end
  endtask

  task automatic test_gradient();
    drive(8'd0, 10'd390, 10'd668);
    step();
    tests_run++;
    if (ifc.sobel_X_out !== 10'd278) begin
      $display("FAIL grad_278: got %0d expected 278", ifc.sobel_X_out);
      tests_failed++;
    end
    drive(8'd0, 10'd15, 10'd10);
    step();
    tests_run++;
    if (ifc.sobel_X_out !== 10'd5) begin
      $display("FAIL grad_5: got %0d expected 5", ifc.sobel_X_out);
      tests_failed++;
    end
    drive(8'd0, 10'd512, 10'd512);
    step();
    tests_run++;
    if (ifc.sobel_X_out !== 10'd0) begin
      $display("FAIL grad_equal: got %0d expected 0", ifc.sobel_X_out);
      tests_failed++;
    end
    drive(8'd0, 10'd1023, 10'd0);
    step();
    tests_run++;
    if (ifc.sobel_X_out !== 10'd1023) begin
      $display("FAIL grad_neg_max: got %0d expected 1023", ifc.sobel_X_out);
      tests_failed++;
    end
  endtask

  task automatic test_max();
    do_reset();
    drive(8'd255, 10'd0, 10'd1023);
    step();
    tests_run++;
    if (ifc.sobel_X_out !== 10'd1023) begin
      $display("FAIL max_sobel: got %0d expected 1023", ifc.sobel_X_out);
      tests_failed++;
    end
    drive(8'd255, 10'd700, 10'd1);
    step();
    tests_run++;
    if (ifc.sobel_X_out !== 10'd699) begin
      $display("FAIL mid_phase_sobel: got %0d expected 699", ifc.sobel_X_out);
      tests_failed++;
    end
    step();
    tests_run++;
    if (ifc.current_intermediate !== 10'd1020) begin
      $display("FAIL max_column: got %0d expected 1020", ifc.current_intermediate);
      tests_failed++;
    end
  endtask

  task automatic test_reset_mid_column();
    do_reset();
    drive(8'd88, 10'd0, 10'd0);
    step();
    drive(8'd121, 10'd0, 10'd0);
    step();
    rst = 1'b1;
    drive(8'd77, 10'd0, 10'd300);
    step();
    tests_run++;
    if (ifc.sobel_X_out !== 10'd0) begin
      $display("FAIL reset_priority_sobel: got %0d expected 0", ifc.sobel_X_out);
      tests_failed++;
    end
    rst = 1'b0;
    drive(8'd10, 10'd0, 10'd0);
    step();
    drive(8'd20, 10'd0, 10'd0);
    step();
    drive(8'd30, 10'd0, 10'd0);
    step();
    tests_run++;
    if (ifc.current_intermediate !== 10'd80) begin
      $display("FAIL reset_mid_column: got %0d expected 80", ifc.current_intermediate);
      tests_failed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rows [6] = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2};
    logic [9:0] exp  [6] = '{10'd0, 10'd0, 10'd4, 10'd4, 10'd4, 10'd8};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(rows[i], 10'd0, 10'd0);
      step();
      tests_run++;
      if (ifc.current_intermediate !== exp[i]) begin
        $display("FAIL back_to_back[%0d]: got %0d expected %0d",
                 i, ifc.current_intermediate, exp[i]);
        tests_failed++;
      end
    end
  endtask

  initial begin
    drive(8'd0, 10'd0, 10'd0);
    test_reset();
    test_column();
    test_gradient();
    test_max();
    test_reset_mid_column();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sequential_sobel_x.md
SEQUENTIAL_SOBEL_X -- requirements
Module: sequential_sobel_x

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 The module SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 current_in  input  8  unsigned pixel of the current column, one row per cycle, top row first.
REQ-006 left_intermediate  input  10  unsigned vertical-smoothed value of the left neighbour column.
REQ-007 right_intermediate  input  10  unsigned vertical-smoothed value of the right neighbour column.
REQ-008 current_intermediate  output  10  registered vertical-smoothed value of the current column.
REQ-009 sobel_X_out  output  10  registered horizontal Sobel gradient magnitude.

Function
REQ-010 The module SHALL keep a 2-bit row phase counter that advances 0->1->2->0 on every non-reset clock edge.
REQ-011 Phase 0: the internal accumulator SHALL load current_in (weight 1).
REQ-012 Phase 1: the accumulator SHALL add 2*current_in (weight 2).
REQ-013 Phase 2, on the same edge:
- current_intermediate SHALL load accumulator + current_in (weight 1).
- The accumulator SHALL clear.
REQ-014 current_intermediate SHALL hold its value except on the phase-2 edge.
- It updates exactly once per 3 cycles.
- The new value is visible after the third sampling edge.
REQ-015 The accumulator and sum SHALL be at least 10 bits unsigned.
- The maximum 255+510+255 = 1020 SHALL never overflow or truncate.
REQ-016 On every non-reset edge, sobel_X_out SHALL load |right_intermediate - left_intermediate|.
- Latency is one cycle, independent of phase.
REQ-017 The difference SHALL be computed at 11-bit signed width, then its absolute value taken.
- The result (0..1023) SHALL fit 10 bits with no saturation needed.
REQ-018 Equal left and right inputs SHALL yield sobel_X_out = 0.
REQ-019 There is no handshake; inputs are sampled every cycle, and the producer SHALL align rows to the phase.

Reset
REQ-020 While rst = 1 at a clock edge:
- phase SHALL be 0.
- The accumulator SHALL be 0.
- current_intermediate SHALL be 0.
- sobel_X_out SHALL be 0.
REQ-021 Reset asserted mid-column SHALL discard the partial accumulation.
- The first edge after rst deasserts is phase 0.
REQ-022 Reset has priority over all other updates on the same edge.
REQ-023 Outputs SHALL be 0 from the first reset edge until the first post-reset update.

Verification
REQ-024 Reset, then current_in = 88, 121, 60 on three consecutive edges -> current_intermediate = 390 after the third edge and held for the next two cycles.
REQ-025 left = 390, right = 668 -> sobel_X_out = 278 one cycle later; then left = 15, right = 10 -> sobel_X_out = 5.
REQ-026 current_in = 255 for three edges -> current_intermediate = 1020; left = 0, right = 1023 -> sobel_X_out = 1023.
REQ-027 left = right = 512 -> sobel_X_out = 0.
REQ-028 Reset asserted after two rows (88, 121), then rows 10, 20, 30 -> current_intermediate = 80; no contribution from 88 or 121.
REQ-029 Continuous columns (1,1,1), then (2,2,2) -> current_intermediate = 4, then 8, each updating on every third edge.
